// File: rtl/sum_entry_ctrl.sv
// sum_entry_ctrl: keypad-driven entry sequencer for the multi-digit two-operand adder.
// Builds operand A, then operand B, one digit key at a time (calculator style). It then
// requests one addition over a req/ack handshake and holds a "result shown" phase until
// the next key arrives.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   key_valid         one-cycle strobe qualifying key_code
//   key_code          0-9 digit, KEY_ENTER, KEY_CLEAR; other codes ignored
//   op_a, op_b        operand nibbles, most significant digit in the top nibble
//   add_req, add_ack  addition handshake to the datapath
//   result_valid      datapath result is meaningful for display
//   err               one-cycle pulse on a digit rejected because the operand is full
//   state_dbg         current state (ENTRY_A=0, ENTRY_B=1, REQ=2, SHOW=3)
module sum_entry_ctrl #(
   parameter int unsigned DIGITS    = 3,
   parameter logic [3:0]  KEY_ENTER = 4'hF,
   parameter logic [3:0]  KEY_CLEAR = 4'hE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                key_valid,
   input  logic [3:0]          key_code,
   output logic [4*DIGITS-1:0] op_a,
   output logic [4*DIGITS-1:0] op_b,
   output logic                add_req,
   input  logic                add_ack,
   output logic                result_valid,
   output logic                err,
   output logic [1:0]          state_dbg
);

   localparam int unsigned OpW  = 4 * DIGITS;
   localparam int unsigned CntW = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {
      StEntryA = 2'd0,
      StEntryB = 2'd1,
      StReq    = 2'd2,
      StShow   = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [OpW-1:0]  op_a_q, op_a_d;
   logic [OpW-1:0]  op_b_q, op_b_d;
   logic [CntW-1:0] count_q, count_d;
   logic            add_req_q, add_req_d;
   logic            result_valid_q, result_valid_d;
   logic            err_q, err_d;
   logic            pending_clear_q, pending_clear_d;

   logic key_digit, key_enter, key_clear;
   logic count_full;
   logic ack_clear;

   assign key_digit  = key_valid && (key_code <= 4'd9);
   assign key_enter  = key_valid && (key_code == KEY_ENTER);
   assign key_clear  = key_valid && (key_code == KEY_CLEAR);
   assign count_full = (count_q == CntW'(DIGITS));
   // A clear arriving in the same cycle as the ack is folded into the pending clear.
   assign ack_clear  = add_ack && (pending_clear_q || key_clear);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEntryA;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StEntryA: begin
            if (!key_clear && key_enter) begin
               state_d = StEntryB;
            end
         end
         StEntryB: begin
            if (key_clear) begin
               state_d = StEntryA;
            end else if (key_enter) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (add_ack) begin
               state_d = ack_clear ? StEntryA : StShow;
            end
         end
         StShow: begin
            if (key_clear || key_digit) begin
               state_d = StEntryA;
            end
         end
         default: state_d = StEntryA;
      endcase
   end

   // Next values of the registered outputs and entry bookkeeping
   always_comb begin
      op_a_d          = op_a_q;
      op_b_d          = op_b_q;
      count_d         = count_q;
      result_valid_d  = result_valid_q;
      pending_clear_d = pending_clear_q;
      err_d           = 1'b0;

      case (state_q)
         StEntryA, StEntryB: begin
            if (key_clear) begin
               op_a_d         = '0;
               op_b_d         = '0;
               count_d        = '0;
               result_valid_d = 1'b0;
            end else if (key_digit) begin
               if (count_full) begin
                  err_d = 1'b1;
               end else begin
                  if (state_q == StEntryA) begin
                     op_a_d = {op_a_q[OpW-5:0], key_code};
                  end else begin
                     op_b_d = {op_b_q[OpW-5:0], key_code};
                  end
                  count_d = count_q + CntW'(1);
               end
            end else if (key_enter) begin
               count_d = '0;
            end
         end
         StReq: begin
            // Operands stay frozen for the whole request; only the clear is remembered.
            if (add_ack) begin
               pending_clear_d = 1'b0;
               if (ack_clear) begin
                  op_a_d         = '0;
                  op_b_d         = '0;
                  count_d        = '0;
                  result_valid_d = 1'b0;
               end else begin
                  result_valid_d = 1'b1;
               end
            end else if (key_clear) begin
               pending_clear_d = 1'b1;
            end
         end
         StShow: begin
            if (key_clear) begin
               op_a_d         = '0;
               op_b_d         = '0;
               count_d        = '0;
               result_valid_d = 1'b0;
            end else if (key_digit) begin
               op_a_d         = OpW'(key_code);
               op_b_d         = '0;
               count_d        = CntW'(1);
               result_valid_d = 1'b0;
            end
         end
         default: begin
            op_a_d          = '0;
            op_b_d          = '0;
            count_d         = '0;
            result_valid_d  = 1'b0;
            pending_clear_d = 1'b0;
         end
      endcase

      add_req_d = (state_d == StReq);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q          <= '0;
         op_b_q          <= '0;
         count_q         <= '0;
         add_req_q       <= 1'b0;
         result_valid_q  <= 1'b0;
         err_q           <= 1'b0;
         pending_clear_q <= 1'b0;
      end else begin
         op_a_q          <= op_a_d;
         op_b_q          <= op_b_d;
         count_q         <= count_d;
         add_req_q       <= add_req_d;
         result_valid_q  <= result_valid_d;
         err_q           <= err_d;
         pending_clear_q <= pending_clear_d;
      end
   end

   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign add_req      = add_req_q;
   assign result_valid = result_valid_q;
   assign err          = err_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_sum_entry_ctrl.sv
// Self-checking bench for sum_entry_ctrl: directed scenarios followed by random key and
// ack traffic, all compared against a behavioural model of the calculator entry rules.
module tb_sum_entry_ctrl;

   logic        clk;
   logic        rst_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [11:0] op_a;
   logic [11:0] op_b;
   logic        add_req;
   logic        add_ack;
   logic        result_valid;
   logic        err;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: phase 0=A entry, 1=B entry, 2=request, 3=show.
   int m_phase, m_a, m_b, m_cnt;
   bit m_req, m_rv, m_err, m_pend;

   sum_entry_ctrl #(
      .DIGITS    (3),
      .KEY_ENTER (4'hF),
      .KEY_CLEAR (4'hE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .op_a         (op_a),
      .op_b         (op_b),
      .add_req      (add_req),
      .add_ack      (add_ack),
      .result_valid (result_valid),
      .err          (err),
      .state_dbg    (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_a = 0; m_b = 0; m_cnt = 0;
      m_req = 0; m_rv = 0; m_err = 0; m_pend = 0;
   endtask

   task automatic model_clear();
      m_phase = 0; m_a = 0; m_b = 0; m_cnt = 0; m_rv = 0; m_pend = 0;
   endtask

   task automatic model_step(input bit kv, input int kc, input bit ack);
      bit dig, ent, clr;
      dig = kv && (kc <= 9);
      ent = kv && (kc == 15);
      clr = kv && (kc == 14);
      m_err = 0;
      case (m_phase)
         0, 1: begin
            if (clr) model_clear();
            else if (dig) begin
               if (m_cnt >= 3) m_err = 1;
               else begin
                  if (m_phase == 0) m_a = (m_a * 16 + kc) % 4096;
                  else m_b = (m_b * 16 + kc) % 4096;
                  m_cnt++;
               end
            end else if (ent) begin
               m_cnt = 0;
               m_phase = m_phase + 1;
            end
         end
         2: begin
            if (ack) begin
               if (m_pend || clr) model_clear();
               else begin
                  m_phase = 3;
                  m_rv = 1;
               end
               m_pend = 0;
            end else if (clr) m_pend = 1;
         end
         default: begin
            if (clr) model_clear();
            else if (dig) begin
               m_a = kc; m_b = 0; m_cnt = 1; m_rv = 0; m_phase = 0;
            end
         end
      endcase
      m_req = (m_phase == 2);
   endtask

   task automatic compare_all();
      check("op_a", 32'(op_a), 32'(m_a));
      check("op_b", 32'(op_b), 32'(m_b));
      check("add_req", 32'(add_req), 32'(m_req));
      check("result_valid", 32'(result_valid), 32'(m_rv));
      check("err", 32'(err), 32'(m_err));
      check("state_dbg", 32'(state_dbg), 32'(m_phase));
   endtask

   // Inputs change at the falling edge; outputs are compared at the next falling edge.
   task automatic tick(input bit kv, input logic [3:0] kc, input bit ack);
      key_valid = kv;
      key_code  = kc;
      add_ack   = ack;
      @(posedge clk);
      model_step(kv, int'(kc), ack);
      @(negedge clk);
      compare_all();
      key_valid = 1'b0;
      add_ack   = 1'b0;
   endtask

   task automatic press(input logic [3:0] kc);
      tick(1'b1, kc, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0);
   endtask

   // Asynchronous reset pulse between edges; add_req must fall without a clock edge.
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, "_add_req_async"}, 32'(add_req), 32'(0));
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      add_ack   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // Reset, then idle
      idle(10);
      check("rst_state", 32'(state_dbg), 32'(0));

      // Full addition with ack 3 cycles after add_req rises
      press(4'h1); press(4'h2); press(4'h3); press(4'hF);
      press(4'h4); press(4'h5); press(4'h6); press(4'hF);
      check("t2_req_rise", 32'(add_req), 32'(1));
      idle(2);
      tick(1'b0, 4'h0, 1'b1);
      check("t2_op_a", 32'(op_a), 32'h123);
      check("t2_op_b", 32'(op_b), 32'h456);
      check("t2_req_drop", 32'(add_req), 32'(0));
      check("t2_state", 32'(state_dbg), 32'(3));
      check("t2_rv", 32'(result_valid), 32'(1));

      // Overflow digit from SHOW
      press(4'h1); press(4'h2); press(4'h3); press(4'h4);
      check("t3_err", 32'(err), 32'(1));
      check("t3_op_a", 32'(op_a), 32'h123);
      idle(1);
      check("t3_err_pulse", 32'(err), 32'(0));
      press(4'hB);
      check("t3_ignored", 32'(op_a), 32'h123);

      // Empty A, clear pending during REQ
      press(4'hE); press(4'hF); press(4'h9); press(4'hF);
      check("t4_req", 32'(state_dbg), 32'(2));
      press(4'hE);
      idle(2);
      check("t4_req_held", 32'(add_req), 32'(1));
      tick(1'b0, 4'h0, 1'b1);
      check("t4_state", 32'(state_dbg), 32'(0));
      check("t4_op_b", 32'(op_b), 32'(0));
      check("t4_rv", 32'(result_valid), 32'(0));

      // SHOW: enter ignored, digit restarts
      press(4'h5); press(4'hF); press(4'h6); press(4'hF);
      tick(1'b0, 4'h0, 1'b1);
      press(4'hF);
      check("t5_show_hold", 32'(state_dbg), 32'(3));
      press(4'h7);
      check("t5_op_a", 32'(op_a), 32'h007);
      check("t5_state", 32'(state_dbg), 32'(0));

      // Reset during request, then clear coincident with ack
      press(4'hF); press(4'hF);
      check("t6_req", 32'(add_req), 32'(1));
      async_reset("t6");
      idle(2);
      press(4'h3); press(4'hF); press(4'h8); press(4'hF);
      tick(1'b1, 4'hE, 1'b1);
      check("t6_coinc_state", 32'(state_dbg), 32'(0));
      check("t6_coinc_op_a", 32'(op_a), 32'(0));

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         int  r;
         bit  kv;
         logic [3:0] kc;
         if ($urandom_range(0, 299) == 0) begin
            async_reset("rnd");
         end else begin
            r  = int'($urandom_range(0, 19));
            kv = ($urandom_range(0, 2) == 0);
            if (r < 10)      kc = 4'(r);
            else if (r < 14) kc = 4'hF;
            else if (r < 16) kc = 4'hE;
            else             kc = 4'(r - 6);
            tick(kv, kc, ($urandom_range(0, 3) == 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sum_entry_ctrl.md
Name: sum_entry_ctrl

Overview:
- Keypad-driven sequencer for the 3-digit two-operand adder datapath.
- Takes debounced key events from the keypad scanner and builds operand A, then operand B, digit by digit, calculator style.
- Requests one addition over a req/ack handshake, then holds a "result shown" phase until the next key.
- Sits between the keypad scanner and the adder/display datapath; replaces change-detect sequencing with explicit key-valid strobes.

Parameters:
- DIGITS, 3, digits per operand; each digit is a 4-bit nibble.
- KEY_ENTER, 4'hF, key code that closes the current operand.
- KEY_CLEAR, 4'hE, key code that clears all entry and returns to operand A.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle
- key_code  in  4  0-9 digit, KEY_ENTER, KEY_CLEAR; all other codes are ignored
- op_a  out  4*DIGITS  operand A nibbles, most significant digit in the top nibble
- op_b  out  4*DIGITS  operand B nibbles, same layout
- add_req  out  1  addition request to the datapath
- add_ack  in  1  datapath has captured the operands
- result_valid  out  1  datapath result is meaningful for display
- err  out  1  one-cycle pulse on a rejected digit
- state_dbg  out  2  current state: ENTRY_A=0, ENTRY_B=1, REQ=2, SHOW=3

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, async): state=ENTRY_A, op_a=0, op_b=0, digit count=0, add_req=0, result_valid=0, err=0, pending_clear=0.
- A key is acted on only in a cycle with key_valid=1, sampled at the rising edge. Its effect is visible on outputs after that edge (1-cycle latency).
- Digit entry (ENTRY_A/ENTRY_B, key 0-9, count<DIGITS):
  - active operand <= {operand[4*DIGITS-5:0], key_code}
  - count increments.
- Digit entry with count==DIGITS: operand unchanged; err=1 for exactly one cycle.
- ENTRY_A + KEY_ENTER: go to ENTRY_B, count=0. Enter with zero digits is legal; the operand stays 0.
- ENTRY_B + KEY_ENTER: go to REQ; add_req=1 from the next cycle.
- REQ:
  - add_req stays high until add_ack=1 is sampled.
  - op_a/op_b are frozen while add_req=1.
  - On ack: add_req=0 the following cycle, state goes to SHOW, result_valid=1.
  - Digit and enter keys are ignored in REQ.
- KEY_CLEAR in ENTRY_A, ENTRY_B or SHOW: op_a=0, op_b=0, count=0, result_valid=0, state goes to ENTRY_A.
- KEY_CLEAR in REQ:
  - The request is never withdrawn; pending_clear is set.
  - On ack, the clear is applied: state goes to ENTRY_A, ops=0, result_valid stays 0.
- key_valid and add_ack in the same REQ cycle: the ack is processed. If the key is KEY_CLEAR, it counts as pending, so the block goes directly to ENTRY_A with ops cleared.
- SHOW:
  - A digit key starts a new calculation: op_a={0…,key}, op_b=0, count=1, result_valid=0, state goes to ENTRY_A.
  - KEY_ENTER is ignored.
- add_ack while not in REQ: ignored.
- Ignored key codes (A-D): no state change, no err.
- Reset asserted mid-operation, including REQ with add_req=1: add_req drops immediately and asynchronously. All state returns to reset values; no pending request survives.
- Illegal state encoding: recover to ENTRY_A on the next edge.

Test Plan:
- Reset then idle 10 cycles -> op_a=0, op_b=0, add_req=0, result_valid=0, state_dbg=0, err never 1.
- Keys 1,2,3,F,4,5,6,F; add_ack raised 3 cycles after add_req rises -> op_a=12'h123, op_b=12'h456; add_req high exactly until ack is sampled; state_dbg=3; result_valid=1.
- Keys 1,2,3,4 -> op_a=12'h123; err pulses one cycle on key 4; state_dbg=0.
- Keys F,9,F then ack -> op_a=0, op_b=12'h009, REQ entered; key E during REQ before ack -> add_req held until ack, then state_dbg=0, op_a=op_b=0, result_valid=0.
- From SHOW: key 7 -> op_a=12'h007, op_b=0, result_valid=0, state_dbg=0. Key F in SHOW -> no change.
- rst_n pulsed low while add_req=1 -> add_req=0 before the next clock edge; all outputs at reset values. Also: key_valid with KEY_CLEAR coincident with add_ack -> ENTRY_A, ops 0.
